// File: rtl/uart_loader_if.sv
// Byte-stream and RAM write-port bundle around uart_loader.
// master = loader side, slave = uart_rx/uart_tx/RAM/CPU side.
interface uart_loader_if #(
    parameter int unsigned XLEN = 32
) ();
    logic [7:0]      uart_rx_data_i;
    logic            uart_rx_data_vld_i;
    logic            uart_rx_data_rdy_o;
    logic [7:0]      uart_tx_data_o;
    logic            uart_tx_data_vld_o;
    logic            uart_tx_data_rdy_i;
    logic            cpu_rst_n_o;
    logic            iram_wr_sel_o;
    logic            dram_wr_sel_o;
    logic [XLEN-1:0] ram_rw_addr_o;
    logic [7:0]      ram_wr_data_o;
    logic [3:0]      ram_wr_byte_en_o;

    modport master (
        input  uart_rx_data_i, uart_rx_data_vld_i, uart_tx_data_rdy_i,
        output uart_rx_data_rdy_o, uart_tx_data_o, uart_tx_data_vld_o, cpu_rst_n_o,
               iram_wr_sel_o, dram_wr_sel_o, ram_rw_addr_o, ram_wr_data_o, ram_wr_byte_en_o
    );

    modport slave (
        output uart_rx_data_i, uart_rx_data_vld_i, uart_tx_data_rdy_i,
        input  uart_rx_data_rdy_o, uart_tx_data_o, uart_tx_data_vld_o, cpu_rst_n_o,
               iram_wr_sel_o, dram_wr_sel_o, ram_rw_addr_o, ram_wr_data_o, ram_wr_byte_en_o
    );
endinterface

// File: rtl/uart_loader.sv
// UART command parser: IRAM/DRAM byte writes and CPU reset control, ACK/NAK reply.
// Optional trailing XOR checksum per write frame when UART_LOADER_CKSUM_EN is defined.
module uart_loader #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input logic            clk_i,
    input logic            rst_n_i,
    uart_loader_if.master  bus
);
    localparam logic [7:0] Ack = 8'h06;
    localparam logic [7:0] Nak = 8'h15;

`ifdef UART_LOADER_CKSUM_EN
    typedef enum logic [2:0] {StIdle, StAddr, StLen, StData, StCksum, StResp} state_e;
`else
    typedef enum logic [2:0] {StIdle, StAddr, StLen, StData, StResp} state_e;
`endif

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic            is_dram_q, is_dram_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [15:0]     len_q, len_d;
    logic            strobe_q, strobe_d;
    logic [31:0]     to_cnt_q, to_cnt_d;
    logic            rx_rdy_q, rx_rdy_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_vld_q, tx_vld_d;
    logic            cpu_rst_n_q, cpu_rst_n_d;
    logic            iram_sel_q, iram_sel_d;
    logic            dram_sel_q, dram_sel_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic [3:0]      byte_en_q, byte_en_d;
`ifdef UART_LOADER_CKSUM_EN
    logic [7:0]      cksum_q, cksum_d;
`endif

    logic       accept;
    logic       timeout;
    logic       go_resp;
    logic [7:0] resp_code;
    logic       write_done;
    logic [7:0] rx_byte;

    assign rx_byte = bus.uart_rx_data_i;
    assign accept  = bus.uart_rx_data_vld_i && rx_rdy_q;
    assign timeout = (to_cnt_q == TIMEOUT_CYCLES);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        is_dram_d   = is_dram_q;
        addr_d      = addr_q;
        len_d       = len_q;
        strobe_d    = strobe_q;
        to_cnt_d    = to_cnt_q;
        tx_data_d   = tx_data_q;
        tx_vld_d    = tx_vld_q;
        cpu_rst_n_d = cpu_rst_n_q;
        iram_sel_d  = iram_sel_q;
        dram_sel_d  = dram_sel_q;
        wr_data_d   = wr_data_q;
        byte_en_d   = byte_en_q;
`ifdef UART_LOADER_CKSUM_EN
        cksum_d     = cksum_q;
`endif
        go_resp     = 1'b0;
        resp_code   = Ack;
        write_done  = 1'b0;

        // Inter-byte watchdog runs only while a frame is partially received.
        if (state_q != StIdle && state_q != StResp) begin
            to_cnt_d = accept ? 32'd0 : to_cnt_q + 32'd1;
        end

        unique case (state_q)
            StIdle: begin
                to_cnt_d = 32'd0;
                if (accept) begin
                    idx_d  = 2'd0;
                    addr_d = '0;
                    len_d  = '0;
`ifdef UART_LOADER_CKSUM_EN
                    cksum_d = 8'h00;
`endif
                    unique case (rx_byte)
                        8'h01, 8'h02: begin
                            is_dram_d   = (rx_byte == 8'h02);
                            cpu_rst_n_d = 1'b0;
                            state_d     = StAddr;
                        end
                        8'h03: begin
                            cpu_rst_n_d = 1'b1;
                            go_resp     = 1'b1;
                        end
                        8'h04: begin
                            cpu_rst_n_d = 1'b0;
                            go_resp     = 1'b1;
                        end
                        default: begin
                            go_resp   = 1'b1;
                            resp_code = Nak;
                        end
                    endcase
                end
            end
            StAddr: begin
                if (accept) begin
                    addr_d = {addr_q[XLEN-9:0], rx_byte};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = StLen;
                    end
                end else if (timeout) begin
                    go_resp   = 1'b1;
                    resp_code = Nak;
                end
            end
            StLen: begin
                if (accept) begin
                    len_d = {len_q[7:0], rx_byte};
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd1) begin
                        if ({len_q[7:0], rx_byte} == 16'd0) begin
                            write_done = 1'b1;
                        end else begin
                            state_d    = StData;
                            iram_sel_d = !is_dram_q;
                            dram_sel_d = is_dram_q;
                        end
                    end
                end else if (timeout) begin
                    go_resp   = 1'b1;
                    resp_code = Nak;
                end
            end
            StData: begin
                // Strobe cycle: retire the byte, then advance address and count.
                if (strobe_q) begin
                    strobe_d  = 1'b0;
                    byte_en_d = 4'b0000;
                    addr_d    = addr_q + 1'b1;
                    len_d     = len_q - 16'd1;
                    if (len_q == 16'd1) begin
                        iram_sel_d = 1'b0;
                        dram_sel_d = 1'b0;
                        write_done = 1'b1;
                    end
                end else if (accept) begin
                    wr_data_d = rx_byte;
                    byte_en_d = 4'(4'b0001 << addr_q[1:0]);
                    strobe_d  = 1'b1;
`ifdef UART_LOADER_CKSUM_EN
                    cksum_d   = cksum_q ^ rx_byte;
`endif
                end else if (timeout) begin
                    iram_sel_d = 1'b0;
                    dram_sel_d = 1'b0;
                    go_resp    = 1'b1;
                    resp_code  = Nak;
                end
            end
`ifdef UART_LOADER_CKSUM_EN
            StCksum: begin
                if (accept) begin
                    go_resp   = 1'b1;
                    resp_code = (rx_byte == cksum_q) ? Ack : Nak;
                end else if (timeout) begin
                    go_resp   = 1'b1;
                    resp_code = Nak;
                end
            end
`endif
            StResp: begin
                if (bus.uart_tx_data_rdy_i) begin
                    tx_vld_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (write_done) begin
`ifdef UART_LOADER_CKSUM_EN
            to_cnt_d = 32'd0;
            state_d  = StCksum;
`else
            go_resp  = 1'b1;
`endif
        end

        if (go_resp) begin
            state_d   = StResp;
            tx_vld_d  = 1'b1;
            tx_data_d = resp_code;
        end

        rx_rdy_d = (state_d != StResp) && !strobe_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            idx_q       <= 2'd0;
            is_dram_q   <= 1'b0;
            addr_q      <= '0;
            len_q       <= 16'd0;
            strobe_q    <= 1'b0;
            to_cnt_q    <= 32'd0;
            rx_rdy_q    <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_vld_q    <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            iram_sel_q  <= 1'b0;
            dram_sel_q  <= 1'b0;
            wr_data_q   <= 8'h00;
            byte_en_q   <= 4'b0000;
`ifdef UART_LOADER_CKSUM_EN
            cksum_q     <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            is_dram_q   <= is_dram_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            strobe_q    <= strobe_d;
            to_cnt_q    <= to_cnt_d;
            rx_rdy_q    <= rx_rdy_d;
            tx_data_q   <= tx_data_d;
            tx_vld_q    <= tx_vld_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            iram_sel_q  <= iram_sel_d;
            dram_sel_q  <= dram_sel_d;
            wr_data_q   <= wr_data_d;
            byte_en_q   <= byte_en_d;
`ifdef UART_LOADER_CKSUM_EN
            cksum_q     <= cksum_d;
`endif
        end
    end

    assign bus.uart_rx_data_rdy_o = rx_rdy_q;
    assign bus.uart_tx_data_o     = tx_data_q;
    assign bus.uart_tx_data_vld_o = tx_vld_q;
    assign bus.cpu_rst_n_o        = cpu_rst_n_q;
    assign bus.iram_wr_sel_o      = iram_sel_q;
    assign bus.dram_wr_sel_o      = dram_sel_q;
    assign bus.ram_rw_addr_o      = addr_q;
    assign bus.ram_wr_data_o      = wr_data_q;
    assign bus.ram_wr_byte_en_o   = byte_en_q;
endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Byte-stream command parser that sits directly downstream of uart_rx. It is an alternative program/data loader to the SPI path.
- Accepts host commands over UART to:
  - write bytes into IRAM or DRAM through the same byte-lane write port the SPI path uses;
  - hold or release the CPU reset.
- Returns a one-byte status (ACK/NAK) toward uart_tx through a valid/ready handshake.

Parameters:
- XLEN, 32, address width of ram_rw_addr_o.
- TIMEOUT_CYCLES, 5000000, inter-byte idle limit in clk_i cycles (100 ms at 50 MHz) before aborting a partial command.

Ports:
- clk_i  input  1  system clock
- rst_n_i  input  1  asynchronous active-low reset
- uart_rx_data_i  input  8  received byte
- uart_rx_data_vld_i  input  1  received byte valid
- uart_rx_data_rdy_o  output  1  loader ready to accept byte
- uart_tx_data_o  output  8  status byte
- uart_tx_data_vld_o  output  1  status byte valid
- uart_tx_data_rdy_i  input  1  uart_tx ready
- cpu_rst_n_o  output  1  CPU reset, active low
- iram_wr_sel_o  output  1  IRAM write session active
- dram_wr_sel_o  output  1  DRAM write session active
- ram_rw_addr_o  output  XLEN  byte address of current write
- ram_wr_data_o  output  8  write byte (replicated to 4 lanes externally)
- ram_wr_byte_en_o  output  4  one-hot lane strobe, zero when not writing

Behaviour:
- Reset: asynchronous, active-low.
  - Outputs go to: cpu_rst_n_o=0, all sel=0, addr=0, wr_data=0, byte_en=0, tx_vld=0, tx_data=0, rx_rdy=0.
  - State goes to IDLE. rx_rdy rises the first cycle after reset release.
- Byte handshake: a byte is accepted when uart_rx_data_vld_i && uart_rx_data_rdy_o.
  - rx_rdy=1 in IDLE, ADDR, LEN, DATA, CKSUM, except in the write-strobe cycle.
  - rx_rdy=0 in RESP.
- Commands, first byte in IDLE:
  - 0x01 = IRAM write.
  - 0x02 = DRAM write.
  - 0x03 = release CPU: cpu_rst_n_o<=1, then ACK.
  - 0x04 = hold CPU: cpu_rst_n_o<=0, then ACK.
  - Any other value = NAK.
- Write frame: cmd, ADDR[31:24..7:0] (4 bytes big-endian), LEN[15:8], LEN[7:0], then LEN data bytes.
- Write sequencing:
  - On acceptance of a 0x01/0x02 command, cpu_rst_n_o<=0 immediately.
  - The matching sel goes to 1 on entering DATA and stays 1 until leaving DATA.
- DATA strobe timing:
  - A byte accepted at cycle N produces, at cycle N+1 for exactly one cycle: wr_data=byte, byte_en=4'b0001<<addr[1:0], ram_rw_addr_o=that byte's address, rx_rdy=0.
  - At N+2: address increments by 1 (wraps 0xFFFFFFFF->0), byte_en returns to 0, and the remaining count decrements.
- Completion:
  - After the strobe of the last byte, go to RESP with ACK 0x06.
  - LEN=0 skips DATA and goes to ACK directly after the LEN bytes; sel never asserts.
- States: IDLE -> ADDR (4 bytes) -> LEN (2 bytes) -> DATA (LEN bytes) -> [CKSUM] -> RESP -> IDLE. Control commands go IDLE -> RESP.
- RESP:
  - tx_vld=1 with tx_data = 0x06 ACK or 0x15 NAK.
  - The byte is held stable until tx_rdy is sampled high; then tx_vld<=0 and state goes to IDLE.
- Timeout:
  - In ADDR/LEN/DATA/CKSUM, a 32-bit counter resets on every accepted byte and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: clear sel, go to RESP with NAK.
  - Bytes already written stay written; cpu_rst_n_o is unchanged.
- Simultaneous events: an rx byte presented during RESP is not accepted; it stays pending in uart_rx.
- Reset mid-frame: the asynchronous reset aborts any frame, and no response is sent.

Optional Feature:
- Macro UART_LOADER_CKSUM_EN.
- Defined:
  - Each write frame carries one trailing byte, CKSUM state, equal to the XOR of all data bytes; for LEN=0 it is 0x00.
  - Match -> ACK 0x06; mismatch -> NAK 0x15. Data is already written, with no rollback.
  - The timeout also applies in CKSUM.
- Undefined: no checksum byte; the CKSUM state and XOR register are not built.

Test Plan:
- Reset then bytes 0x01,0x00,0x00,0x00,0x02,0x00,0x03,0xAA,0xBB,0xCC (plus checksum 0xDD if the macro is defined) -> three strobes: addr 0x2/byte_en 0100/data 0xAA, addr 0x3/1000/0xBB, addr 0x4/0001/0xCC; iram_wr_sel_o high only during DATA; tx byte 0x06; cpu_rst_n_o=0.
- Byte 0x03 -> cpu_rst_n_o=1 and ACK 0x06. Then 0x02 with addr 0x00000010, LEN 0 -> cpu_rst_n_o=0, no strobe, dram_wr_sel_o never high, ACK.
- Byte 0x7F -> NAK 0x15. Next frame parses normally.
- DRAM write at addr 0xFFFFFFFF, LEN 2 -> strobes at 0xFFFFFFFF (byte_en 1000) then 0x00000000 (byte_en 0001).
- Send 0x01 plus 2 address bytes, then idle TIMEOUT_CYCLES (shortened to 100 in the bench) -> NAK 0x15, state IDLE, no strobe issued.
- Hold uart_tx_data_rdy_i=0 for 50 cycles during RESP -> tx_vld and tx_data stable and rx_rdy=0 throughout. ACK completes on the first cycle rdy=1.
